// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - signal bundle between the hex counter logic and the seven-segment scan driver
//
// Purpose: groups the digit-value inputs and the display-pin outputs of
// seg_scan_driver so both sides connect through one port.
//
// Signals:
//   digits    [31:0] hex digit values, digit i = digits[4i+3:4i]
//   dig_en    [7:0]  per-digit enable, 0 forces that anode off
//   dp_in     [7:0]  per-digit decimal point request, active-high
//   blank_lz         1 = suppress leading zeros
//   seg       [6:0]  {g,f,e,d,c,b,a}, active-low
//   dp               decimal point, active-low
//   an        [7:0]  anodes, active-low, an[i] drives digit i
//   div_clk          scan-rate square wave for the counter logic
//   scan_tick        one-clock pulse at each slot boundary
//
// Modports:
//   master - counter logic / board side: drives digit data, receives pins
//   slave  - the scan driver itself

interface seg_scan_driver_if;
  logic [31:0] digits;
  logic [7:0]  dig_en;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        div_clk;
  logic        scan_tick;

  modport master (
    output digits, dig_en, dp_in, blank_lz,
    input  seg, dp, an, div_clk, scan_tick
  );

  modport slave (
    input  digits, dig_en, dp_in, blank_lz,
    output seg, dp, an, div_clk, scan_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 8-digit common-anode seven-segment scan driver
//
// Purpose: divides clk into digit slots of TICK_DIV clocks, scans the digits
// in order 0..N_DIG-1, and drives active-low segment/anode pins from a
// snapshot that is refreshed once per frame. Each slot opens with BLANK_CYC
// clocks of all anodes off to stop ghosting between digits. Digits can be
// disabled individually, and leading zeros can be blanked.
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-low
//   bus  slave modport of seg_scan_driver_if
//        (digits, dig_en, dp_in, blank_lz in; seg, dp, an, div_clk, scan_tick out)
//
// Parameters:
//   TICK_DIV   system clocks per digit slot, minimum 4
//   N_DIG      digits scanned, 1..8
//   BLANK_CYC  blank clocks at the start of each slot, less than TICK_DIV

module seg_scan_driver #(
  parameter int TICK_DIV  = 100000,
  parameter int N_DIG     = 8,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [2:0]    IDX_LAST  = 3'(N_DIG - 1);

  // ST_PRIME covers the first slot after reset: no snapshot has been taken
  // yet, so nothing is lit. The first tick takes the snapshot and starts the
  // scan at digit 0 instead of advancing the index.
  typedef enum logic {
    ST_PRIME,
    ST_SCAN
  } state_t;

  state_t        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    idx_q,     idx_d;

  logic [31:0]   snap_digits_q, snap_digits_d;
  logic [7:0]    snap_en_q,     snap_en_d;
  logic [7:0]    snap_dp_q,     snap_dp_d;
  logic          snap_blz_q,    snap_blz_d;

  logic          div_clk_q,   div_clk_d;
  logic          scan_tick_q, scan_tick_d;
  logic [7:0]    an_q,        an_d;
  logic [6:0]    seg_q,       seg_d;
  logic          dp_q,        dp_d;

  logic          tick;
  logic          take_snap;
  logic [7:0]    sup;
  logic          zero_run;
  logic [3:0]    nib;
  logic          show;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Divider, index and snapshot next-state.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    state_d   = state_q;
    idx_d     = idx_q;
    take_snap = 1'b0;

    if (tick) begin
      if (state_q == ST_PRIME) begin
        state_d   = ST_SCAN;
        idx_d     = 3'd0;
        take_snap = 1'b1;
      end else if (idx_q == IDX_LAST) begin
        idx_d     = 3'd0;
        take_snap = 1'b1;
      end else begin
        idx_d     = idx_q + 3'd1;
      end
    end

    // The snapshot is captured on the same edge the index wraps, so inputs
    // present on that clock belong to the new frame.
    snap_digits_d = take_snap ? bus.digits   : snap_digits_q;
    snap_en_d     = take_snap ? bus.dig_en   : snap_en_q;
    snap_dp_d     = take_snap ? bus.dp_in    : snap_dp_q;
    snap_blz_d    = take_snap ? bus.blank_lz : snap_blz_q;

    // scan_tick is registered but must be high while the counter sits at
    // its last value, so it is derived from the next count.
    scan_tick_d = (cnt_d == CNT_LAST);
    div_clk_d   = tick ? ~div_clk_q : div_clk_q;
  end

  // Leading-zero suppression: walk down from the top digit while every digit
  // seen so far is zero. Digit 0 is always shown.
  always_comb begin
    sup      = '0;
    zero_run = snap_blz_d;
    for (int i = 7; i >= 0; i--) begin
      if (i < N_DIG) begin
        zero_run = zero_run & (snap_digits_d[4*i +: 4] == 4'h0);
        if (i != 0) begin
          sup[i] = zero_run;
        end
      end
    end
  end

  // Pin values for the next clock; decoding from the next-state snapshot and
  // index keeps snapshot-to-pin latency at one clock.
  always_comb begin
    nib  = snap_digits_d[{idx_d, 2'b00} +: 4];
    show = (state_d == ST_SCAN) && (cnt_d >= CNT_BLANK) &&
           snap_en_d[idx_d] && !sup[idx_d];

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (show) begin
      an_d[idx_d] = 1'b0;
      seg_d       = seg7(nib);
      dp_d        = ~snap_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_PRIME;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= '0;
      snap_blz_q    <= 1'b0;
      div_clk_q     <= 1'b0;
      scan_tick_q   <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      snap_blz_q    <= snap_blz_d;
      div_clk_q     <= div_clk_d;
      scan_tick_q   <= scan_tick_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.div_clk   = div_clk_q;
  assign bus.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver

module tb_seg_scan_driver;

  localparam int TICK_DIV  = 4;
  localparam int N_DIG     = 8;
  localparam int BLANK_CYC = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg_scan_driver_if bus();

  seg_scan_driver #(
    .TICK_DIV  (TICK_DIV),
    .N_DIG     (N_DIG),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at a falling edge where scan_tick is high.
  task automatic sync_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.scan_tick !== 1'b1 && n < 50);
    chk_eq(tag, bus.scan_tick, 1);
  endtask

  // Starts at a falling edge with scan_tick high; checks one full slot and
  // ends on the falling edge where the next scan_tick is high.
  task automatic check_slot(input string tag, input logic [7:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
    @(negedge clk);
    chk_eq({tag, "_blank_an"}, bus.an, 8'hFF);
    chk_eq({tag, "_blank_seg"}, bus.seg, 7'h7F);
    for (int c = 1; c < TICK_DIV; c++) begin
      @(negedge clk);
      chk_eq($sformatf("%s_an_c%0d", tag, c), bus.an, e_an);
      chk_eq($sformatf("%s_seg_c%0d", tag, c), bus.seg, e_seg);
      chk_eq($sformatf("%s_dp_c%0d", tag, c), bus.dp, e_dp);
      chk_eq($sformatf("%s_tick_c%0d", tag, c), bus.scan_tick, (c == TICK_DIV - 1) ? 1 : 0);
    end
  endtask

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] t1_seg [8];
    logic [6:0] t3_seg [8];
    logic       d0;
    int         n;
    int         k;

    t1_seg = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40};
    t3_seg = '{7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bus.digits   = 32'h0000_1234;
    bus.dig_en   = 8'hFF;
    bus.dp_in    = 8'h00;
    bus.blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_an", bus.an, 8'hFF);
    chk_eq("rst_seg", bus.seg, 7'h7F);
    chk_eq("rst_dp", bus.dp, 1);
    chk_eq("rst_div_clk", bus.div_clk, 0);
    chk_eq("rst_scan_tick", bus.scan_tick, 0);
    rst = 1'b1;

    // Test 1: first slot after release is unlit, then digits 0..7
    sync_tick("t1_first_tick");
    chk_eq("t1_prime_an", bus.an, 8'hFF);
    for (int i = 0; i < N_DIG; i++)
      check_slot($sformatf("t1_s%0d", i), an_of(i), t1_seg[i], 1'b1);

    // Test 2: leading-zero blanking, changed on the wrap clock itself
    bus.blank_lz = 1'b1;
    for (int i = 0; i < N_DIG; i++)
      if (i < 4) check_slot($sformatf("t2_s%0d", i), an_of(i), t1_seg[i], 1'b1);
      else       check_slot($sformatf("t2_s%0d", i), 8'hFF, 7'h7F, 1'b1);
    bus.digits = 32'h0000_0000;
    check_slot("t2z_s0", 8'hFE, 7'h40, 1'b1);
    for (int i = 1; i < N_DIG; i++)
      check_slot($sformatf("t2z_s%0d", i), 8'hFF, 7'h7F, 1'b1);

    // Test 3: mid-frame change only appears from the next frame
    bus.blank_lz = 1'b0;
    bus.digits   = 32'h0000_00FF;
    check_slot("t3a_s0", 8'hFE, 7'h0E, 1'b1);
    bus.digits = 32'h0000_0100;
    check_slot("t3a_s1", 8'hFD, 7'h0E, 1'b1);
    for (int i = 2; i < N_DIG; i++)
      check_slot($sformatf("t3a_s%0d", i), an_of(i), 7'h40, 1'b1);
    for (int i = 0; i < N_DIG; i++)
      check_slot($sformatf("t3b_s%0d", i), an_of(i), t3_seg[i], 1'b1);

    // Test 4: only digit 0 enabled, with its decimal point
    bus.digits = 32'h0000_1234;
    bus.dig_en = 8'h01;
    bus.dp_in  = 8'h01;
    check_slot("t4_s0", 8'hFE, 7'h19, 1'b0);
    for (int i = 1; i < N_DIG; i++)
      check_slot($sformatf("t4_s%0d", i), 8'hFF, 7'h7F, 1'b1);

    // Test 5: div_clk toggles once per tick, scan_tick one clock per toggle
    d0 = bus.div_clk;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk_eq($sformatf("t5_div_clk_%0d", j), bus.div_clk, d0 ^ ((((j - 1) / 4) + 1) & 1));
      chk_eq($sformatf("t5_tick_%0d", j), bus.scan_tick, (j % 4 == 0) ? 1 : 0);
    end
    bus.dig_en = 8'hFF;
    bus.dp_in  = 8'h00;

    // Test 6: asynchronous reset during slot 3
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.an !== 8'hF7 && n < 200);
    chk_eq("t6_slot3_an", bus.an, 8'hF7);
    chk_eq("t6_slot3_seg", bus.seg, 7'h79);
    #2 rst = 1'b0;
    #1;
    chk_eq("t6_async_an", bus.an, 8'hFF);
    chk_eq("t6_async_seg", bus.seg, 7'h7F);
    chk_eq("t6_async_dp", bus.dp, 1);
    chk_eq("t6_async_div_clk", bus.div_clk, 0);
    chk_eq("t6_async_tick", bus.scan_tick, 0);
    bus.digits = 32'h0000_5678;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.an === 8'hFF && k < 20);
    chk_eq("t6_first_lit_cycle", k, 5);
    chk_eq("t6_first_lit_an", bus.an, 8'hFE);
    chk_eq("t6_first_lit_seg", bus.seg, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
